amiga_wom_banks: RTL and testbench

AMIGA_WOM_BANKS -- requirements
Module: amiga_wom_banks

---
 rtl/amiga_wom_banks.sv | 206 ++++++++++++++++++++
 tb/tb_amiga_wom_banks.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/amiga_wom_banks.sv
// amiga_wom_banks: cycle controller for NBANK x 256 KiB RAM banks.
// Banks 0..WOM_BANKS-1 are write-once memory. A bank starts unlocked and can
// be loaded or overlaid by the boot ROM. The first write with _SROM negated
// locks it. After that it behaves as read-only RAM.
// Optional feature macro: WOM_BERR_EN. When it is defined, a write to a locked
// bank raises _BERR. Otherwise that write is silently dropped.
module amiga_wom_banks #(
    parameter int NBANK     = 4,
    parameter int WOM_BANKS = 1
) (
    input  logic                     C7M,
    input  logic                     RES,
    input  logic                     _RE,
    input  logic                     _PRW,
    input  logic                     _UDS,
    input  logic                     _LDS,
    input  logic [$clog2(NBANK)-1:0] BANK,
    input  logic                     _SROM,
    input  logic                     _ROME,
    output logic                     _UCEN,
    output logic                     _LCEN,
    output logic                     _CDR,
    output logic                     _CDW,
    output logic                     _RRW,
    output logic                     _ROM01,
    output logic                     _BERR,
    output logic [NBANK-1:0]         _WPRO
);

    typedef enum logic [1:0] {IDLE, ACTIVE, ERR, RECOVER} state_t;
    typedef enum logic [2:0] {CYC_RAM_RD, CYC_RAM_WR, CYC_ROM_RD, CYC_LOCK, CYC_ILLEGAL} cyc_t;

    state_t                   state_q, state_d;
    cyc_t                     cyc_q, cyc_d, cyc_new;
    logic [$clog2(NBANK)-1:0] bank_q, bank_d;
    logic                     uds_q, uds_d, lds_q, lds_d;
    logic                     block_q, block_d;
    logic [NBANK-1:0]         wpro_q, wpro_d;
    logic                     ucen_q, ucen_d, lcen_q, lcen_d;
    logic                     cdr_q, cdr_d, cdw_q, cdw_d;
    logic                     rrw_q, rrw_d, rom01_q, rom01_d;
`ifdef WOM_BERR_EN
    logic                     berr_q, berr_d;
`endif

    logic re, uds, lds, any_strobe, rd, srom, rome;
    logic bank_wom, bank_locked;

    assign re         = ~_RE;
    assign uds        = ~_UDS;
    assign lds        = ~_LDS;
    assign any_strobe = uds | lds;
    assign rd         = _PRW;
    assign srom       = ~_SROM;
    assign rome       = ~_ROME;

    // Classify the cycle that would start now, based on the live bus and the lock bits
    always_comb begin
        bank_wom    = (32'(BANK) < 32'(WOM_BANKS));
        bank_locked = wpro_q[BANK];
        cyc_new     = CYC_RAM_RD;
        if (!bank_wom) begin
            cyc_new = rd ? CYC_RAM_RD : CYC_RAM_WR;
        end else if (bank_locked) begin
            cyc_new = rd ? CYC_RAM_RD : CYC_ILLEGAL;
        end else if (rd) begin
            cyc_new = (!srom && rome) ? CYC_ROM_RD : CYC_RAM_RD;
        end else begin
            cyc_new = srom ? CYC_RAM_WR : CYC_LOCK;
        end
    end

    // Next-state logic: latch the cycle in IDLE, hold on strobes, one recovery cycle
    always_comb begin
        state_d = state_q;
        cyc_d   = cyc_q;
        bank_d  = bank_q;
        uds_d   = uds_q;
        lds_d   = lds_q;
        block_d = block_q;
        wpro_d  = wpro_q;
        case (state_q)
            IDLE: begin
                if (!any_strobe) begin
                    block_d = 1'b0;
                end
                if (re && any_strobe && !block_q) begin
                    bank_d = BANK;
                    uds_d  = uds;
                    lds_d  = lds;
                    cyc_d  = cyc_new;
`ifdef WOM_BERR_EN
                    state_d = (cyc_new == CYC_ILLEGAL) ? ERR : ACTIVE;
`else
                    state_d = ACTIVE;
`endif
                end
            end
            ACTIVE: begin
                if (!any_strobe) begin
                    state_d = RECOVER;
                    if (cyc_q == CYC_LOCK) begin
                        wpro_d[bank_q] = 1'b1;
                    end
                end
            end
            ERR: begin
                if (!any_strobe && !re) begin
                    state_d = RECOVER;
                end
            end
            RECOVER: begin
                state_d = IDLE;
                block_d = any_strobe;
            end
            default: state_d = IDLE;
        endcase
    end

    // Output decode from the upcoming state, so the registered enables line up with it
    always_comb begin
        ucen_d  = 1'b0;
        lcen_d  = 1'b0;
        cdr_d   = 1'b0;
        cdw_d   = 1'b0;
        rrw_d   = 1'b0;
        rom01_d = 1'b0;
        if (state_d == ACTIVE) begin
            case (cyc_d)
                CYC_RAM_RD: begin
                    cdr_d  = 1'b1;
                    ucen_d = uds_d;
                    lcen_d = lds_d;
                end
                CYC_RAM_WR: begin
                    cdw_d  = 1'b1;
                    rrw_d  = 1'b1;
                    ucen_d = uds_d;
                    lcen_d = lds_d;
                end
                CYC_ROM_RD: begin
                    cdr_d   = 1'b1;
                    rom01_d = 1'b1;
                end
                default: ;
            endcase
        end
`ifdef WOM_BERR_EN
        berr_d = (state_d == ERR);
`endif
    end

    // State, latched cycle info, lock bits and registered enables
    always_ff @(posedge C7M or posedge RES) begin
        if (RES) begin
            state_q <= IDLE;
            cyc_q   <= CYC_RAM_RD;
            bank_q  <= '0;
            uds_q   <= 1'b0;
            lds_q   <= 1'b0;
            block_q <= 1'b0;
            wpro_q  <= '0;
            ucen_q  <= 1'b0;
            lcen_q  <= 1'b0;
            cdr_q   <= 1'b0;
            cdw_q   <= 1'b0;
            rrw_q   <= 1'b0;
            rom01_q <= 1'b0;
`ifdef WOM_BERR_EN
            berr_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cyc_q   <= cyc_d;
            bank_q  <= bank_d;
            uds_q   <= uds_d;
            lds_q   <= lds_d;
            block_q <= block_d;
            wpro_q  <= wpro_d;
            ucen_q  <= ucen_d;
            lcen_q  <= lcen_d;
            cdr_q   <= cdr_d;
            cdw_q   <= cdw_d;
            rrw_q   <= rrw_d;
            rom01_q <= rom01_d;
`ifdef WOM_BERR_EN
            berr_q  <= berr_d;
`endif
        end
    end

    // Internal flags are active-high. A set lock bit drives its _WPRO pin low.
    assign _UCEN  = ~ucen_q;
    assign _LCEN  = ~lcen_q;
    assign _CDR   = ~cdr_q;
    assign _CDW   = ~cdw_q;
    assign _RRW   = ~rrw_q;
    assign _ROM01 = ~rom01_q;
    assign _WPRO  = ~wpro_q;
`ifdef WOM_BERR_EN
    assign _BERR  = ~berr_q;
`else
    assign _BERR  = 1'b1;
`endif

endmodule

// File: tb/tb_amiga_wom_banks.sv
// tb_amiga_wom_banks: directed bench for amiga_wom_banks with NBANK=8 and WOM_BANKS=3.
// It keeps a transaction-level model of the expected bus enables and the lock bits.
// This model is compared with the DUT on every clock cycle.
module tb_amiga_wom_banks;

    localparam int NB = 8;
    localparam int WB = 3;
    localparam logic [6:0] OUT_IDLE = 7'b1111111;

    typedef enum int {K_RAM_RD, K_RAM_WR, K_ROM_RD, K_LOCK, K_ILLEGAL} kind_t;

    logic       c7m = 1'b0;
    logic       res = 1'b0;
    logic       re_n, prw, uds_n, lds_n, srom_n, rome_n;
    logic [2:0] bank;
    logic       ucen_n, lcen_n, cdr_n, cdw_n, rrw_n, rom01_n, berr_n;
    logic [7:0] wpro_n;
    logic [6:0] dut_out;
    logic [6:0] seen;

    int         n_assert = 0;
    int         n_fail   = 0;
    logic [6:0] exp_out    = OUT_IDLE;
    logic [7:0] lock_model = 8'h00;

    amiga_wom_banks #(.NBANK(NB), .WOM_BANKS(WB)) dut (
        .C7M   (c7m),
        .RES   (res),
        ._RE   (re_n),
        ._PRW  (prw),
        ._UDS  (uds_n),
        ._LDS  (lds_n),
        .BANK  (bank),
        ._SROM (srom_n),
        ._ROME (rome_n),
        ._UCEN (ucen_n),
        ._LCEN (lcen_n),
        ._CDR  (cdr_n),
        ._CDW  (cdw_n),
        ._RRW  (rrw_n),
        ._ROM01(rom01_n),
        ._BERR (berr_n),
        ._WPRO (wpro_n)
    );

    assign dut_out = {ucen_n, lcen_n, cdr_n, cdw_n, rrw_n, rom01_n, berr_n};

    always #5 c7m = ~c7m;

    // Work out the kind of cycle from the write-once rules and the modelled lock bits
    function automatic kind_t modelClassify(input int b, input bit write, input bit srom, input bit rome);
        if (b >= WB) return write ? K_RAM_WR : K_RAM_RD;
        if (lock_model[b]) return write ? K_ILLEGAL : K_RAM_RD;
        if (!write) return (!srom && rome) ? K_ROM_RD : K_RAM_RD;
        return srom ? K_RAM_WR : K_LOCK;
    endfunction

    // Give the active-low output vector {UCEN,LCEN,CDR,CDW,RRW,ROM01,BERR} for a cycle kind
    function automatic logic [6:0] modelOutputs(input kind_t k, input bit uds, input bit lds);
        logic [6:0] v;
        v = OUT_IDLE;
        case (k)
            K_RAM_RD: begin v[6] = ~uds; v[5] = ~lds; v[4] = 1'b0; end
            K_RAM_WR: begin v[6] = ~uds; v[5] = ~lds; v[3] = 1'b0; v[2] = 1'b0; end
            K_ROM_RD: begin v[4] = 1'b0; v[1] = 1'b0; end
`ifdef WOM_BERR_EN
            K_ILLEGAL: v[0] = 1'b0;
`endif
            default: ;
        endcase
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [7:0] actual, input logic [7:0] expected);
        n_assert++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s at %0t: got %b, expected %b", name, $time, actual, expected);
        end
    endtask

    task automatic tickEdge();
        @(posedge c7m);
        #1;
    endtask

    task automatic driveBus(input bit re, input bit write, input bit uds, input bit lds,
                            input int b, input bit srom, input bit rome);
        re_n   = ~re;
        prw    = ~write;
        uds_n  = ~uds;
        lds_n  = ~lds;
        bank   = 3'(b);
        srom_n = ~srom;
        rome_n = ~rome;
    endtask

    // Run one bus cycle. Latched inputs change while it is active, and its active-phase outputs are returned.
    task automatic applyStimulus(input int b, input bit write, input bit uds, input bit lds,
                                 input bit srom, input bit rome, input int hold,
                                 output logic [6:0] active_out);
        kind_t k;
        k = modelClassify(b, write, srom, rome);
        driveBus(1'b1, write, uds, lds, b, srom, rome);
        tickEdge();
        exp_out = modelOutputs(k, uds, lds);
        #1;
        active_out = dut_out;
        bank   = 3'(b ^ 1);
        prw    = ~prw;
        srom_n = ~srom_n;
        re_n   = 1'b1;
        repeat (hold) tickEdge();
        uds_n = 1'b1;
        lds_n = 1'b1;
        tickEdge();
        exp_out = OUT_IDLE;
        if (k == K_LOCK) lock_model[b] = 1'b1;
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, b, srom, rome);
        tickEdge();
    endtask

    // Compare the outputs and lock bits on every cycle, well clear of the clock edge
    initial begin
        forever begin
            @(posedge c7m);
            #3;
            checkOutput("cycle_outputs", {1'b0, dut_out}, {1'b0, exp_out});
            checkOutput("cycle_wpro", wpro_n, ~lock_model);
        end
    end

    // Directed sequence
    initial begin
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b0);
        #1 res = 1'b1;
        #1;
        checkOutput("reset_outputs", {1'b0, dut_out}, 8'h7F);
        checkOutput("reset_wpro", wpro_n, 8'hFF);
        tickEdge();
        tickEdge();
        res = 1'b0;
        tickEdge();

        $display("[TB] software-ROM load write to bank 0");
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, seen);
        checkOutput("srom_write_bank0", {1'b0, seen}, 8'b00010011);
        checkOutput("wpro_after_srom_write", wpro_n, 8'hFF);

        $display("[TB] ROM overlay read, lock write, RAM read on bank 0");
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("rom_read_bank0", {1'b0, seen}, 8'b01101101);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("lock_write_bank0", {1'b0, seen}, 8'h7F);
        checkOutput("wpro_after_lock0", wpro_n, 8'hFE);
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("ram_read_locked0", {1'b0, seen}, 8'b00001111);

        $display("[TB] illegal writes to locked bank 0");
        applyStimulus(0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 2, seen);
`ifdef WOM_BERR_EN
        checkOutput("illegal_write_berr", {1'b0, seen}, 8'b01111110);
`else
        checkOutput("illegal_write_dropped", {1'b0, seen}, 8'h7F);
`endif
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1, seen);
        checkOutput("wpro_after_illegal", wpro_n, 8'hFE);

        $display("[TB] unlocked WOM bank 1 read with ROM disabled");
        applyStimulus(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1, seen);

        $display("[TB] plain bank 5 write, lock bank 2, UDS-only read bank 6");
        applyStimulus(5, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("plain_write_bank5", {1'b0, seen}, 8'b00010011);
        checkOutput("wpro_after_bank5", wpro_n, 8'hFE);
        applyStimulus(2, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("wpro_after_lock2", wpro_n, 8'hFA);
        applyStimulus(6, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1, seen);
        checkOutput("uds_read_bank6", {1'b0, seen}, 8'b00101111);

        $display("[TB] strobe held through recovery must not restart");
        driveBus(1'b1, 1'b0, 1'b1, 1'b1, 4, 1'b0, 1'b1);
        tickEdge();
        exp_out = modelOutputs(modelClassify(4, 1'b0, 1'b0, 1'b1), 1'b1, 1'b1);
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
        tickEdge();
        exp_out = OUT_IDLE;
        driveBus(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1);
        repeat (3) tickEdge();
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
        tickEdge();
        driveBus(1'b1, 1'b0, 1'b1, 1'b0, 4, 1'b0, 1'b1);
        tickEdge();
        exp_out = modelOutputs(modelClassify(4, 1'b0, 1'b0, 1'b1), 1'b1, 1'b0);
        #1;
        checkOutput("restart_after_release", {1'b0, dut_out}, 8'b00101111);
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 4, 1'b0, 1'b1);
        tickEdge();
        exp_out = OUT_IDLE;
        tickEdge();

        $display("[TB] asynchronous reset during an active RAM write");
        driveBus(1'b1, 1'b1, 1'b1, 1'b1, 7, 1'b0, 1'b1);
        tickEdge();
        exp_out = modelOutputs(modelClassify(7, 1'b1, 1'b0, 1'b1), 1'b1, 1'b1);
        res        = 1'b1;
        exp_out    = OUT_IDLE;
        lock_model = 8'h00;
        driveBus(1'b0, 1'b0, 1'b0, 1'b0, 0, 1'b0, 1'b1);
        #1;
        checkOutput("async_reset_outputs", {1'b0, dut_out}, 8'h7F);
        checkOutput("async_reset_wpro", wpro_n, 8'hFF);
        tickEdge();
        res = 1'b0;
        tickEdge();
        applyStimulus(0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("rom_read_after_reset", {1'b0, seen}, 8'b01101101);
        applyStimulus(0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1, seen);
        checkOutput("relock_after_reset", wpro_n, 8'hFE);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
